// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the CPU request/response handshake and the data-memory bus of the
// load/store unit.
//   req_*  : CPU request (valid/ready handshake, size, sign, address, data)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : word-aligned data-memory port (combinational read, posedge write)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (CPU plus data memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
        output mem_read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Executes one CPU load or store at a time against a word-wide data memory.
// Byte and halfword stores are done read-modify-write; loads extract the
// addressed little-endian lane and sign- or zero-extend it.
// Ports:
//   clk   : single clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Parameter:
//   WORDS : data-memory depth in 32-bit words (word index >= WORDS is an error)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned WORDS = 32
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;     // word read from memory in READ
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Misalignment / range check on the incoming (not yet registered) request.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        req_err = 1'b0;
        case (bus.req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.req_addr[0];
            SZ_WORD: req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= WORDS) begin
            req_err = 1'b1;
        end
    end

    // Store merge: replace only the addressed lane(s) of the old word.
    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extraction and extension.
    always_comb begin
        lane8     = word_q[{addr_q[1:0], 3'b000} +: 8];
        lane16    = word_q[{addr_q[1], 4'b0000} +: 16];
        load_data = word_q;
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & lane8[7]}}, lane8};
            SZ_HALF: load_data = {{16{signed_q & lane16[15]}}, lane16};
            default: load_data = word_q;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
        err_d    = err_q;

        bus.req_ready      = (state_q == IDLE);
        bus.rsp_valid      = 1'b0;
        bus.rsp_rdata      = 32'h0;
        bus.rsp_err        = 1'b0;
        bus.mem_address    = 32'h0;
        bus.mem_write_data = 32'h0;
        bus.mem_MemWrite   = 1'b0;
        bus.mem_MemRead    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    size_d   = bus.req_size;
                    write_d  = bus.req_write;
                    signed_d = bus.req_signed;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        // Loads and sub-word stores both need the old word.
                        state_d = READ;
                    end
                end
            end
            READ: begin
                bus.mem_MemRead = 1'b1;
                bus.mem_address = {addr_q[31:2], 2'b00};
                word_d          = bus.mem_read_data;
                state_d         = write_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_MemWrite   = 1'b1;
                bus.mem_address    = {addr_q[31:2], 2'b00};
                bus.mem_write_data = merged;
                state_d            = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (err_q || write_q) ? 32'h0 : load_data;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the asynchronous reset forces IDLE immediately, which also drops
    // the combinational memory strobes of an interrupted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            size_q   <= size_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORDS, 32, data-memory depth in 32-bit words; word index addr>>2 >= WORDS is out of range.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as misaligned.
REQ-008 req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word and stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned or out-of-range request, valid with rsp_valid.
REQ-014 mem_address  output  32  byte address to data memory, always word-aligned (bits[1:0] = 0).
REQ-015 mem_write_data  output  32  word written to data memory.
REQ-016 mem_MemWrite  output  1  memory write enable; memory writes at the posedge ending the cycle.
REQ-017 mem_MemRead  output  1  memory read enable; memory returns data combinationally.
REQ-018 mem_read_data  input  32  data-memory read word.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE and RESP; req_ready SHALL equal (state == IDLE).
REQ-020 A request is accepted at a posedge with req_valid && req_ready; all request fields SHALL be registered on acceptance.
REQ-021 Error check on accept, with err if any holds, SHALL be:
- halfword with addr[0] = 1;
- word with addr[1:0] != 0;
- size 11;
- out of range.
An erroring request SHALL go IDLE->RESP and issue no mem_MemRead or mem_MemWrite.
REQ-022 Load path SHALL be IDLE->READ->RESP:
- READ drives mem_MemRead = 1 and mem_address = {addr[31:2], 2'b00};
- the read word is captured at the end of READ.
REQ-023 Word store path SHALL be IDLE->WRITE->RESP, with WRITE driving mem_MemWrite = 1 and mem_write_data = req_wdata.
REQ-024 Sub-word store path SHALL be IDLE->READ->WRITE->RESP:
- READ captures the old word;
- WRITE drives the merged word: only the addressed lane(s) are replaced, all other bits are preserved.
REQ-025 Lanes SHALL be little-endian: byte offset k occupies bits [8k+7:8k]; the halfword at offset 0 occupies [15:0] and at offset 2 occupies [31:16].
REQ-026 Load extraction SHALL select the lane by addr[1:0] (halfword by addr[1]) and extend it to 32 bits per req_signed.
REQ-027 RESP SHALL last exactly one cycle with rsp_valid = 1, then return to IDLE.
REQ-028 Outside RESP, rsp_valid, rsp_rdata and rsp_err SHALL be 0.
REQ-029 Latency from the accepting edge SHALL be: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle (rsp_valid high in that cycle).
REQ-030 In IDLE and RESP, mem_MemRead, mem_MemWrite, mem_address and mem_write_data SHALL all be 0.
REQ-031 mem_MemRead and mem_MemWrite SHALL never be 1 in the same cycle.
REQ-032 req_valid while not ready SHALL be ignored; the CPU holds the request until accepted.

Reset
REQ-033 On rst_n low, state SHALL become IDLE immediately (asynchronously).
REQ-034 While rst_n is low, all outputs SHALL be 0 except req_ready, and all registered request and data fields SHALL clear to 0.
REQ-035 req_ready SHALL be 1 from the first cycle rst_n is high.
REQ-036 Reset asserted in READ or WRITE SHALL drop mem_MemWrite and mem_MemRead combinationally; the interrupted access is abandoned, with no write and no response.

Verification (memory initially all zero, WORDS = 32)
REQ-037 Word store/load: sw 0xDEADBEEF @0x08, then lw @0x08 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; rsp_valid high 2 cycles after each accepting edge.
REQ-038 Byte store, signed/unsigned byte loads:
- sb 0x000000AB @0x09 -> word@0x08 = 0xDEADABEF, rsp_valid 3 cycles after accept;
- lb signed @0x09 -> 0xFFFFFFAB;
- lbu @0x09 -> 0x000000AB.
REQ-039 Halfword store/load: sh 0x00001234 @0x0A -> word@0x08 = 0x1234ABEF; lhu @0x0A -> 0x00001234; lh signed @0x08 -> 0xFFFFABEF.
REQ-040 Errors, each giving rsp_err = 1, rsp_rdata = 0, rsp_valid 1 cycle after accept, and mem_MemRead and mem_MemWrite never asserted:
- lh @0x03;
- sw @0x06;
- lw @0x80.
REQ-041 Reset mid-store:
- drive sw 0x11111111 @0x10 and assert rst_n low during WRITE;
- mem_MemWrite = 0 immediately and no rsp_valid;
- after release, lw @0x10 -> 0x00000000.
REQ-042 Back-to-back: req_valid held high with 3 queued loads -> req_ready = 0 in READ/RESP, each load completes in order, and no request is lost or duplicated.
